// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_arb_pkg
// Purpose  : Shared types and defaults for the two-port ROM arbiter.
//            Holds the response-owner encoding, the default ROM depth and
//            the default starvation limit, plus a helper that maps the
//            per-cycle grants to the owner of the next-cycle response.
// Macros   : none (ROM_ARB_ALIGN_CHK_EN is consumed by rom_port_arbiter)
// Revision : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

  // Which port the registered ROM response belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

  localparam int ROM_SIZE_DEF     = 160;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int ADDR_W           = 31;
  localparam int DATA_W           = 32;

  // Grants are mutually exclusive; fetch is tested first only for clarity.
  function automatic owner_e owner_of(input logic if_gnt, input logic ld_gnt);
    if (if_gnt) begin
      return OWN_IF;
    end else if (ld_gnt) begin
      return OWN_LD;
    end
    return OWN_NONE;
  endfunction

endpackage : rom_arb_pkg
`default_nettype wire

// File: rtl/rom_arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : rom_arb_prio
// Purpose  : Grant logic for the ROM arbiter. Load has fixed priority over
//            fetch, except once fetch has lost STARVE_LIMIT consecutive
//            cycles, at which point fetch wins.
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset (grants forced low)
//            if_req_i  - fetch request
//            ld_req_i  - load request
//            if_gnt_o  - fetch grant (combinational)
//            ld_gnt_o  - load grant (combinational)
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
module rom_arb_prio
  import rom_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req_i,
  input  logic ld_req_i,
  output logic if_gnt_o,
  output logic ld_gnt_o
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             w_fetch_wins;

  always_comb begin
    w_fetch_wins = (starve_q == C_LIMIT);
    // Grants are gated by rst_n so nothing is issued while reset is held.
    if_gnt_o = rst_n & if_req_i & (w_fetch_wins | ~ld_req_i);
    ld_gnt_o = rst_n & ld_req_i & ~if_gnt_o;

    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (starve_q != C_LIMIT) begin
      starve_d = starve_q + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule : rom_arb_prio
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_port_arbiter
// Purpose  : Shares one combinational ROM between an instruction-fetch port
//            and a data-load port. One grant per cycle, response one cycle
//            later on the granted port. Fetch responses can be squashed by
//            if_flush_i in the response cycle.
// Ports    : clk, rst_n                  - clock / async active-low reset
//            if_req_i, if_addr_i         - fetch request and byte address
//            if_flush_i                  - squash fetch response this cycle
//            if_gnt_o                    - fetch granted (combinational)
//            if_rvalid_o/if_rdata_o/if_err_o - fetch response
//            ld_req_i, ld_addr_i         - load request and byte address
//            ld_gnt_o                    - load granted (combinational)
//            ld_rvalid_o/ld_rdata_o/ld_err_o - load response
//            rom_addr_o                  - address to the ROM
//            rom_data_i, rom_overflow_i  - same-cycle ROM data / range flag
// Macros   : ROM_ARB_ALIGN_CHK_EN - when defined, a granted address with
//            addr[1:0] != 0 returns err=1, rdata=0.
// Revision : 1.0 - initial release
// ============================================================================
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ROM_SIZE     = ROM_SIZE_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  output logic [DATA_W-1:0] ld_rdata_o,
  output logic              ld_err_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              rom_overflow_i
);

  localparam logic [ADDR_W-3:0] C_LAST_IDX = (ADDR_W-2)'(ROM_SIZE - 1);

  owner_e            owner_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [DATA_W-1:0] if_hold_q;
  logic [DATA_W-1:0] ld_hold_q;

  logic              w_range_err;
  logic              w_misalign;
  logic              w_err;

  rom_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req_i (if_req_i),
    .ld_req_i (ld_req_i),
    .if_gnt_o (if_gnt_o),
    .ld_gnt_o (ld_gnt_o)
  );

  // With no grant the ROM still sees the fetch address.
  assign rom_addr_o = ld_gnt_o ? ld_addr_i : if_addr_i;

  // Local range check backs up the ROM's own overflow flag.
  assign w_range_err = (rom_addr_o[ADDR_W-1:2] > C_LAST_IDX);

`ifdef ROM_ARB_ALIGN_CHK_EN
  assign w_misalign = (rom_addr_o[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = rom_overflow_i | w_range_err | w_misalign;

  // Owner FSM and shared response registers. The per-port hold registers
  // keep the last delivered word so rdata is stable while rvalid is low,
  // including a squashed fetch response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      if_hold_q   <= '0;
      ld_hold_q   <= '0;
    end else begin
      owner_q <= owner_of(if_gnt_o, ld_gnt_o);
      if (if_gnt_o || ld_gnt_o) begin
        resp_err_q  <= w_err;
        resp_data_q <= w_err ? '0 : rom_data_i;
      end
      if (if_rvalid_o) begin
        if_hold_q <= resp_data_q;
      end
      if (ld_rvalid_o) begin
        ld_hold_q <= resp_data_q;
      end
    end
  end

  always_comb begin
    if_rvalid_o = (owner_q == OWN_IF) & ~if_flush_i;
    if_err_o    = if_rvalid_o & resp_err_q;
    if_rdata_o  = if_rvalid_o ? resp_data_q : if_hold_q;

    ld_rvalid_o = (owner_q == OWN_LD);
    ld_err_o    = ld_rvalid_o & resp_err_q;
    ld_rdata_o  = ld_rvalid_o ? resp_data_q : ld_hold_q;
  end

endmodule : rom_port_arbiter
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_port_arbiter
// Purpose  : Directed self-checking bench for rom_port_arbiter with a small
//            combinational ROM model (word i = 32'hC0DE_0000 | i, 160 words).
// Macros   : ROM_ARB_ALIGN_CHK_EN selects the misaligned-fetch expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [30:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ld_req = 1'b0;
  logic [30:0] ld_addr = '0;
  logic        ld_gnt, ld_rvalid, ld_err;
  logic [31:0] ld_rdata;
  logic [30:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_overflow;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_ld = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [28:0] idx);
    return 32'hC0DE_0000 | {3'b000, idx};
  endfunction

  always_comb begin
    rom_data     = rom_word(rom_addr[30:2]);
    rom_overflow = (rom_addr[30:2] >= 29'd160);
  end

  rom_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_i       (if_req),
    .if_addr_i      (if_addr),
    .if_flush_i     (if_flush),
    .if_gnt_o       (if_gnt),
    .if_rvalid_o    (if_rvalid),
    .if_rdata_o     (if_rdata),
    .if_err_o       (if_err),
    .ld_req_i       (ld_req),
    .ld_addr_i      (ld_addr),
    .ld_gnt_o       (ld_gnt),
    .ld_rvalid_o    (ld_rvalid),
    .ld_rdata_o     (ld_rdata),
    .ld_err_o       (ld_err),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data),
    .rom_overflow_i (rom_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req   = 1'b0;
    ld_req   = 1'b0;
    if_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    if_req = 1'b1;
    ld_req = 1'b1;
    #2;
    checks++;
    if ({if_gnt, ld_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL reset_grants: got %b expected 00", {if_gnt, ld_gnt});
    end
    checks++;
    if ({if_rvalid, ld_rvalid, if_err, ld_err, if_rdata, ld_rdata} !== 68'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {if_rvalid, ld_rvalid, if_err, ld_err, if_rdata, ld_rdata});
    end
    step();
    idle();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_basic();
    if_req  = 1'b1;
    if_addr = 31'h0;
    #1;
    checks++;
    if ({if_gnt, ld_gnt, rom_addr} !== {2'b10, 31'h0}) begin
      errors++;
      $display("FAIL fetch_gnt: got %b %h expected 10 0", {if_gnt, ld_gnt}, rom_addr);
    end
    step();
    idle();
    #1;
    checks++;
    if ({if_rvalid, if_err, if_rdata, ld_rvalid} !== {1'b1, 1'b0, rom_word(29'd0), 1'b0}) begin
      errors++;
      $display("FAIL fetch_resp: got v=%b e=%b d=%h ldv=%b expected 1 0 %h 0",
               if_rvalid, if_err, if_rdata, ld_rvalid, rom_word(29'd0));
    end
    last_if = rom_word(29'd0);
    step();
  endtask

  task automatic test_starve();
    logic [1:0] exp_g;
    if_addr = 31'h10;
    ld_addr = 31'h20;
    if_req  = 1'b1;
    ld_req  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      #1;
      exp_g = (c == 5) ? 2'b10 : 2'b01;
      checks++;
      if ({if_gnt, ld_gnt} !== exp_g) begin
        errors++;
        $display("FAIL starve_gnt_c%0d: got %b expected %b", c, {if_gnt, ld_gnt}, exp_g);
      end
      if (c > 1) begin
        checks++;
        if (c - 1 == 5) begin
          if ({if_rvalid, ld_rvalid, if_rdata} !== {2'b10, rom_word(29'd4)}) begin
            errors++;
            $display("FAIL starve_resp_c%0d: got %b%b %h expected 10 %h",
                     c - 1, if_rvalid, ld_rvalid, if_rdata, rom_word(29'd4));
          end
        end else begin
          if ({if_rvalid, ld_rvalid, ld_rdata} !== {2'b01, rom_word(29'd8)}) begin
            errors++;
            $display("FAIL starve_resp_c%0d: got %b%b %h expected 01 %h",
                     c - 1, if_rvalid, ld_rvalid, ld_rdata, rom_word(29'd8));
          end
        end
      end
      step();
    end
    idle();
    #1;
    checks++;
    if ({if_rvalid, ld_rvalid, ld_rdata} !== {2'b01, rom_word(29'd8)}) begin
      errors++;
      $display("FAIL starve_resp_c6: got %b%b %h expected 01 %h",
               if_rvalid, ld_rvalid, ld_rdata, rom_word(29'd8));
    end
    last_if = rom_word(29'd4);
    last_ld = rom_word(29'd8);
    step();
  endtask

  task automatic test_range();
    ld_req  = 1'b1;
    ld_addr = 31'h280;
    #1;
    checks++;
    if ({ld_gnt, rom_addr} !== {1'b1, 31'h280}) begin
      errors++;
      $display("FAIL range_gnt: got %b %h expected 1 280", ld_gnt, rom_addr);
    end
    step();
    ld_addr = 31'h27C;
    #1;
    checks++;
    if ({ld_rvalid, ld_err, ld_rdata, if_rvalid} !== {2'b11, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL range_word160: got v=%b e=%b d=%h expected 1 1 0", ld_rvalid, ld_err, ld_rdata);
    end
    step();
    idle();
    #1;
    checks++;
    if ({ld_rvalid, ld_err, ld_rdata} !== {2'b10, rom_word(29'd159)}) begin
      errors++;
      $display("FAIL range_word159: got v=%b e=%b d=%h expected 1 0 %h",
               ld_rvalid, ld_err, ld_rdata, rom_word(29'd159));
    end
    step();
    checks++;
    if ({ld_rvalid, ld_err, ld_rdata} !== {2'b00, rom_word(29'd159)}) begin
      errors++;
      $display("FAIL range_hold: got v=%b e=%b d=%h expected 0 0 %h",
               ld_rvalid, ld_err, ld_rdata, rom_word(29'd159));
    end
    last_ld = rom_word(29'd159);
  endtask

  task automatic test_flush();
    if_req  = 1'b1;
    if_addr = 31'h8;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_if_gnt: got %b expected 1", if_gnt);
    end
    step();
    if_req   = 1'b0;
    if_flush = 1'b1;
    ld_req   = 1'b1;
    ld_addr  = 31'hC;
    #1;
    checks++;
    if ({if_rvalid, if_err, if_rdata, ld_gnt} !== {2'b00, last_if, 1'b1}) begin
      errors++;
      $display("FAIL flush_squash: got v=%b e=%b d=%h ldg=%b expected 0 0 %h 1",
               if_rvalid, if_err, if_rdata, ld_gnt, last_if);
    end
    step();
    idle();
    #1;
    checks++;
    if ({ld_rvalid, ld_err, ld_rdata, if_rvalid} !== {2'b10, rom_word(29'd3), 1'b0}) begin
      errors++;
      $display("FAIL flush_ld_resp: got v=%b e=%b d=%h ifv=%b expected 1 0 %h 0",
               ld_rvalid, ld_err, ld_rdata, if_rvalid, rom_word(29'd3));
    end
    last_ld = rom_word(29'd3);
    // Flush coinciding with the grant must not cancel it.
    if_req   = 1'b1;
    if_addr  = 31'h14;
    if_flush = 1'b1;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_same_cycle_gnt: got %b expected 1", if_gnt);
    end
    step();
    idle();
    #1;
    checks++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b10, rom_word(29'd5)}) begin
      errors++;
      $display("FAIL flush_same_cycle_resp: got v=%b e=%b d=%h expected 1 0 %h",
               if_rvalid, if_err, if_rdata, rom_word(29'd5));
    end
    last_if = rom_word(29'd5);
    step();
  endtask

  task automatic test_align();
    logic [33:0] exp_r;
`ifdef ROM_ARB_ALIGN_CHK_EN
    exp_r = {2'b11, 32'h0};
`else
    exp_r = {2'b10, rom_word(29'd1)};
`endif
    if_req  = 1'b1;
    if_addr = 31'h6;
    #1;
    checks++;
    if ({if_gnt, rom_addr} !== {1'b1, 31'h6}) begin
      errors++;
      $display("FAIL align_gnt: got %b %h expected 1 6", if_gnt, rom_addr);
    end
    step();
    idle();
    #1;
    checks++;
    if ({if_rvalid, if_err, if_rdata} !== exp_r) begin
      errors++;
      $display("FAIL align_resp: got %h expected %h", {if_rvalid, if_err, if_rdata}, exp_r);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_g;
    if_addr = 31'h0;
    ld_addr = 31'h4;
    if_req  = 1'b1;
    ld_req  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
    end
    // A load response is now pending and fetch has lost three cycles.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err, if_rdata, ld_rdata} !== 70'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err, if_rdata, ld_rdata});
    end
    step();
    idle();
    rst_n = 1'b1;
    step();
    checks++;
    if ({if_rvalid, ld_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_no_rvalid: got %b expected 00", {if_rvalid, ld_rvalid});
    end
    if_req = 1'b1;
    ld_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      exp_g = (c == 5) ? 2'b10 : 2'b01;
      checks++;
      if ({if_gnt, ld_gnt} !== exp_g) begin
        errors++;
        $display("FAIL midreset_starve_c%0d: got %b expected %b", c, {if_gnt, ld_gnt}, exp_g);
      end
      step();
    end
    idle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch_basic();
    test_starve();
    test_range();
    test_flush();
    test_align();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rom_port_arbiter
`default_nettype wire

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter ROM_SIZE, default 160, SHALL be the number of 32-bit ROM words; word index = addr[30:2].
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL be the consecutive lost-arbitration cycles after which fetch wins.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  instruction-fetch request; held with if_addr stable until if_gnt.
REQ-006 if_addr  in  31  fetch byte address.
REQ-007 if_flush  in  1  squash fetch response due next cycle (branch/exception).
REQ-008 if_gnt  out  1  fetch granted this cycle (combinational).
REQ-009 if_rvalid  out  1  fetch response valid.
REQ-010 if_rdata  out  32  fetch instruction word.
REQ-011 if_err  out  1  fetch address out of range (or misaligned, see REQ-030).
REQ-012 ld_req / ld_addr / ld_gnt / ld_rvalid / ld_rdata / ld_err: same widths and meanings as fetch set, for data-load port.
REQ-013 rom_addr  out  31  address driven to the combinational ROM.
REQ-014 rom_data  in  32  ROM read data, same cycle as rom_addr.
REQ-015 rom_overflow  in  1  ROM out-of-range flag, same cycle as rom_addr.

Function
REQ-016 At most one grant SHALL be issued per cycle; rom_addr SHALL equal the granted port's address, else if_addr.
REQ-017 Arbitration SHALL be fixed priority load over fetch, except when starve_cnt == STARVE_LIMIT, then fetch SHALL win.
REQ-018 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle if_req is high and not granted; clear on if_gnt or if_req low.
REQ-019 Granted cycle N: rom_data, rom_overflow SHALL be registered; the granted port's rvalid, rdata, err SHALL assert in cycle N+1 only (latency 1, throughput 1/cycle).
REQ-020 On err, rdata SHALL be 32'h0.
REQ-021 Response routing SHALL use a registered owner state: NONE, IF, LD; owner = granted port at N, NONE if no grant.
REQ-022 if_flush high in cycle N+1 with owner IF SHALL force if_rvalid=0 and if_err=0 that cycle; load responses unaffected.
REQ-023 if_flush high in the cycle of if_gnt SHALL NOT cancel the grant; the response is suppressed only if flush is high in N+1.
REQ-024 rvalid of the non-owner port SHALL be 0; rdata of both ports SHALL hold last value when not valid.
REQ-025 Both requests simultaneous with starve_cnt < STARVE_LIMIT: ld granted, starve_cnt increments.
REQ-026 Address with addr[30:2] == ROM_SIZE-1: no error; addr[30:2] == ROM_SIZE: err=1.

Reset
REQ-027 While reset low: owner=NONE, starve_cnt=0, if_rvalid=ld_rvalid=0, if_err=ld_err=0, if_rdata=ld_rdata=0; grants forced 0.
REQ-028 Reset asserted mid-transaction SHALL discard the pending response; no rvalid after release until a new grant.
REQ-029 First grant SHALL be possible in the first rising edge after reset deasserts.

Configuration
REQ-030 Macro ROM_ARB_ALIGN_CHK_EN defined: granted addr[1:0] != 0 SHALL set err=1 with rdata=0 (ROM still addressed); undefined: addr[1:0] ignored, err = rom_overflow only.

Structure
REQ-031 Shared package rom_arb_pkg SHALL hold the owner encoding (NONE=2'd0, IF=2'd1, LD=2'd2) and ROM_SIZE default constant.
REQ-032 Sub-module rom_arb_prio SHALL hold grant logic and starve counter; top holds response registers and owner FSM.

Verification
REQ-033 if_req only, if_addr=0x0 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=rom word 0, if_err=0.
REQ-034 ld_req and if_req held high 6 cycles -> ld granted cycles 1-4, if granted cycle 5, ld cycle 6.
REQ-035 ld_addr=0x280 (word 160) -> ld_rvalid=1, ld_err=1, ld_rdata=0; addr 0x27C -> ld_err=0.
REQ-036 if granted cycle N, if_flush=1 in N+1 -> if_rvalid=0 in N+1; back-to-back load response unaffected.
REQ-037 reset low in cycle after a grant -> no rvalid, all outputs 0, starve_cnt 0.
REQ-038 ROM_ARB_ALIGN_CHK_EN defined, if_addr=0x6 -> if_err=1; undefined -> if_err=0, if_rdata = word 1.
